// File: rtl/out_uart_tx.sv
// rtl/out_uart_tx.sv - capture FIFO for the Out register feeding an LSB-first UART serialiser
// Define OUT_UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module out_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             i_load_en,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_full,
  output logic             o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef OUT_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    baud;
  logic [IW-1:0]    bit_idx;
  state_t           state;
  logic             empty;
  logic             tick;
  logic             pop;
  logic             wr_req;
  logic             do_wr;
`ifdef OUT_UART_TX_PARITY_EN
  logic             parity;
`endif

  assign empty  = (wr_ptr == rd_ptr);
  assign o_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];
  assign tick   = (baud == BAUD_LAST);
  // The stop-bit tick pops the next byte so consecutive frames have no idle gap.
  assign pop    = !empty && ((state == IDLE) || ((state == STOP) && tick));
  assign wr_req = clk_en && i_load_en;
  assign do_wr  = wr_req && (!o_full || pop);
  assign o_busy = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= i_load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_req && !do_wr) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_tx    <= 1'b1;
`ifdef OUT_UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      baud <= ((state == IDLE) || tick) ? '0 : baud + 1'b1;
      if (pop) begin
        shift <= head;
        state <= START;
        o_tx  <= 1'b0;
`ifdef OUT_UART_TX_PARITY_EN
        parity <= ^head;
`endif
      end else if (tick) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            o_tx    <= shift[0];
          end
          DATA: begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
`ifdef OUT_UART_TX_PARITY_EN
              state <= PARITY;
              o_tx  <= parity;
`else
              state <= STOP;
              o_tx  <= 1'b1;
`endif
            end else begin
              o_tx <= shift[1];
            end
          end
`ifdef OUT_UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            o_tx  <= 1'b1;
          end
`endif
          STOP: begin
            state <= IDLE;
            o_tx  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_out_uart_tx.sv
// tb/tb_out_uart_tx.sv - out_uart_tx bench checking every cycle against a frame-level queue model
// Honours OUT_UART_TX_PARITY_EN the same way as the design.
module tb_out_uart_tx;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int C     = 4;
`ifdef OUT_UART_TX_PARITY_EN
  localparam int FRAME_BITS = W + 3;
`else
  localparam int FRAME_BITS = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clk_en = 1'b0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         tx, busy, full, ovf;

  int errs = 0;
  int checks = 0;
  int n = 0;

  // Model: bytes waiting, the frame on the line and when it ends.
  logic [W-1:0] q[$];
  logic         m_active = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] m_byte = '0;
  int           m_start = 0;
  int           m_end = 0;

  out_uart_tx #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_load_en(load_en),
    .i_load_data(load_data), .o_tx(tx), .o_busy(busy), .o_full(full),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(logic [W-1:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= W) return b[k-1];
    if (k == W + 1 && FRAME_BITS == W + 3) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s at edge %0d: got %b expected %b", tag, n, got, exp);
    end
  endtask

  task automatic step();
    logic pop;
    n++;
    if (rst_n) begin
      pop = (q.size() > 0) && (!m_active || n == m_end);
      if (m_active && n == m_end) m_active = 1'b0;
      if (pop) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_start  = n;
        m_end    = n + FRAME_BITS * C;
      end
      if (clk_en && load_en) begin
        if (q.size() < DEPTH) q.push_back(load_data);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("tx", tx, m_active ? frame_bit(m_byte, (n - m_start) / C) : 1'b1);
    chk("busy", busy, m_active || (q.size() > 0));
    chk("full", full, q.size() == DEPTH);
    chk("overflow", ovf, m_ovf);
  endtask

  task automatic idle(int k);
    repeat (k) step();
  endtask

  task automatic write(logic [W-1:0] d);
    clk_en = 1'b1;
    load_en = 1'b1;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (m_active || q.size() > 0); i++) step();
    step();
    chk("drained_busy", busy, 1'b0);
  endtask

  // Asserts reset between clock edges so the async path is observed directly.
  task automatic do_reset();
    load_en = 1'b0;
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    m_active = 1'b0;
    m_ovf = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    do_reset();

    // Single byte: start bit one edge after the strobe, 40-cycle frame.
    write(8'hA5);
    step();
    chk("latency_tx_low", tx, 1'b0);
    idle(39);
    step();
    chk("single_done_busy", busy, 1'b0);

    // Three consecutive writes: contiguous frames.
    write(8'h01);
    write(8'h02);
    write(8'h03);
    drain();

    // Strobe without clk_en is ignored.
    clk_en = 1'b0;
    load_en = 1'b1;
    load_data = 8'h5A;
    idle(10);
    load_en = 1'b0;
    chk("gated_busy", busy, 1'b0);
    chk("gated_tx", tx, 1'b1);

    // Six back-to-back writes: FIFO fills, sixth dropped, overflow sticky.
    repeat (5) write(W'($urandom));
    chk("burst_full", full, 1'b1);
    write(W'($urandom));
    chk("burst_overflow", ovf, 1'b1);
    drain();
    chk("overflow_sticky", ovf, 1'b1);

    // Write while full at the same edge as the stop-tick pop.
    do_reset();
    repeat (5) write(W'($urandom));
    chk("pre_pop_full", full, 1'b1);
    for (int i = 0; i < 200 && (n + 1) != m_end; i++) step();
    write(W'($urandom));
    chk("pop_write_ovf", ovf, 1'b0);
    chk("pop_write_full", full, 1'b1);
    drain();

    // Reset in the middle of a data bit discards everything.
    write(8'h00);
    write(8'h3C);
    write(8'hC3);
    idle(12);
    do_reset();
    idle(60);
    chk("post_reset_busy", busy, 1'b0);

`ifdef OUT_UART_TX_PARITY_EN
    write(8'h07);
    idle(37);
    chk("parity_bit", tx, 1'b1);
    drain();
`endif

    // Random traffic, light then heavy enough to overflow.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      load_en = ($urandom_range(0, 99) < ((i < 200) ? 4 : 40));
      load_data = W'($urandom);
      step();
    end
    load_en = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
